axi_burst_mem_slave: RTL and testbench

//  Word-addressed AXI4 memory slave with INCR bursts, byte strobes, IDs, error responses and configurable read latency.

---
 rtl/axi_burst_mem_slave_if.sv | 59 +++++
 rtl/axi_burst_mem_slave.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 bus bundle for the burst memory slave: AW/W/B write channels and AR/R read channels.
// The slave modport is the memory side, the master modport is the requester side.
interface axi_burst_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// Word-addressed AXI4 memory slave: INCR bursts, byte strobes, SLVERR on out-of-range beats
// or wlast disagreement, and a programmable read latency. One burst in flight per direction.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting beats 0..awlen
// W_RESP | bvalid high with bid/bresp held until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | down-counting the extra read latency cycles
// R_DATA | rvalid high, beat held until rready
module axi_burst_mem_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int INIT_OPTION  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_burst_mem_slave_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDXW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [2:0] LAT_LOAD = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef logic [DATA_WIDTH-1:0] mem_t [MEM_DEPTH];

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            img[i] = (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
        end
        return img;
    endfunction

    // Power-up image only; reset leaves the contents alone.
    mem_t mem = init_image();

    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_beat_q, w_beat_d;
    logic                  w_err_q, w_err_d;
    logic [ADDR_WIDTH:0]   w_beat_addr;
    logic                  w_in_range;
    logic                  w_last_beat;
    logic                  w_fire;

    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic [2:0]            r_cnt_q, r_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  fetch;
    logic [ADDR_WIDTH-1:0] f_base;
    logic [7:0]            f_beat;
    logic [7:0]            f_len;
    logic [ADDR_WIDTH:0]   f_addr;

    always_comb begin
        w_state_d   = w_state_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_beat_d    = w_beat_q;
        w_err_d     = w_err_q;
        w_fire      = 1'b0;
        w_beat_addr = {1'b0, w_addr_q} + (ADDR_WIDTH+1)'(w_beat_q);
        w_in_range  = (w_beat_addr < DEPTH_EXT);
        w_last_beat = (w_beat_q == w_len_q);
        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    w_id_d    = bus.awid;
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    w_fire   = 1'b1;
                    w_beat_d = w_beat_q + 8'd1;
                    // Burst length comes from awlen; a mismatched wlast only flags the response.
                    if (!w_in_range || (bus.wlast != w_last_beat)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && w_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.wstrb[b]) begin
                    mem[w_beat_addr[IDXW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.awready = (w_state_q == W_IDLE);
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bid     = w_id_q;
    assign bus.bresp   = {w_err_q, 1'b0};

    // Memory is sampled combinationally a cycle ahead of rvalid, so a same-edge write is not seen.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        fetch     = 1'b0;
        f_base    = r_addr_q;
        f_beat    = r_beat_q + 8'd1;
        f_len     = r_len_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_id_d   = bus.arid;
                    r_addr_d = bus.araddr;
                    r_len_d  = bus.arlen;
                    r_beat_d = '0;
                    if (READ_LATENCY == 1) begin
                        fetch     = 1'b1;
                        f_base    = bus.araddr;
                        f_beat    = '0;
                        f_len     = bus.arlen;
                        r_state_d = R_DATA;
                    end else begin
                        r_cnt_d   = LAT_LOAD;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 3'd0) begin
                    fetch     = 1'b1;
                    f_beat    = '0;
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q - 3'd1;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        fetch    = 1'b1;
                        r_beat_d = r_beat_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        f_addr = {1'b0, f_base} + (ADDR_WIDTH+1)'(f_beat);
        if (fetch) begin
            rlast_d = (f_beat == f_len);
            if (f_addr < DEPTH_EXT) begin
                rdata_d = mem[f_addr[IDXW-1:0]];
                rresp_d = 2'b00;
            end else begin
                rdata_d = '0;
                rresp_d = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_DATA);
    assign bus.rid     = r_id_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave (1024 words, read latency 3, index-valued power-up image):
// hand-written burst sequences plus a table of single-word readbacks with hand-computed results.
module tb_axi_burst_mem_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_burst_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_burst_mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MEM_DEPTH(DEPTH), .READ_LATENCY(LAT), .INIT_OPTION(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } rv_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_n;
    int          rd_wait;
    int          rd_unstable;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int last_at, output logic [1:0] resp, output logic [3:0] rbid);
        int n;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin tick(); n++; end
        if (n >= 50) check("awready_wait", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wdata  = wd[i];
            bus.wstrb  = ws[i];
            bus.wlast  = (i == last_at);
            bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 50) begin tick(); n++; end
            if (n >= 50) check("wready_wait", bus.wready, 1);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin tick(); n++; end
        if (n >= 50) check("bvalid_wait", bus.bvalid, 1);
        resp = bus.bresp;
        rbid = bus.bid;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input bit toggle);
        int n;
        logic [38:0] held;
        bit prev_stall;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin tick(); n++; end
        if (n >= 50) check("arready_wait", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
        rd_wait = 0;
        while (!bus.rvalid && rd_wait < 50) begin tick(); rd_wait++; end
        rd_n        = 0;
        rd_unstable = 0;
        prev_stall  = 1'b0;
        held        = '0;
        bus.rready  = toggle ? 1'b0 : 1'b1;
        n = 0;
        while (rd_n <= len && n < 200) begin
            if (bus.rvalid) begin
                if (prev_stall && ({bus.rdata, bus.rresp, bus.rlast, bus.rid} != held)) rd_unstable++;
                if (bus.rready) begin
                    rd_data[rd_n] = bus.rdata;
                    rd_resp[rd_n] = bus.rresp;
                    rd_last[rd_n] = bus.rlast;
                    rd_id[rd_n]   = bus.rid;
                    rd_n++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held = {bus.rdata, bus.rresp, bus.rlast, bus.rid};
                end
            end else begin
                if (prev_stall) rd_unstable++;
                prev_stall = 1'b0;
            end
            tick();
            n++;
            if (toggle) bus.rready = ~bus.rready;
        end
        bus.rready = 1'b0;
        check("r_beats", rd_n, len + 1);
        check("r_idle_after", bus.rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rv_t tbl [19];
        logic [1:0] resp;
        logic [3:0] rbid;
        bit saw_b;

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        tbl[0]  = '{32'd5,    32'h11BB33DD, 2'b00};
        tbl[1]  = '{32'd16,   32'h000000A0, 2'b00};
        tbl[2]  = '{32'd19,   32'h000000A3, 2'b00};
        tbl[3]  = '{32'd100,  32'd100,      2'b00};
        tbl[4]  = '{32'd999,  32'd999,      2'b00};
        tbl[5]  = '{32'd1022, 32'h0000D000, 2'b00};
        tbl[6]  = '{32'd1023, 32'h0000D001, 2'b00};
        tbl[7]  = '{32'd1024, 32'h00000000, 2'b10};
        tbl[8]  = '{32'd5000, 32'h00000000, 2'b10};
        tbl[9]  = '{32'd300,  32'h0000E000, 2'b00};
        tbl[10] = '{32'd302,  32'h0000E002, 2'b00};
        tbl[11] = '{32'd303,  32'h0000E003, 2'b00};
        tbl[12] = '{32'd310,  32'h00005100, 2'b00};
        tbl[13] = '{32'd311,  32'h00005101, 2'b00};
        tbl[14] = '{32'd400,  32'h0000F000, 2'b00};
        tbl[15] = '{32'd401,  32'h0000F001, 2'b00};
        tbl[16] = '{32'd402,  32'd402,      2'b00};
        tbl[17] = '{32'd407,  32'd407,      2'b00};
        tbl[18] = '{32'd201,  32'hC0DE0001, 2'b00};

        // reset values
        #2;
        check("rst_awready", bus.awready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_wready",  bus.wready,  0);
        check("rst_bvalid",  bus.bvalid,  0);
        check("rst_rvalid",  bus.rvalid,  0);
        check("rst_rlast",   bus.rlast,   0);
        check("rst_resp",    {bus.bresp, bus.rresp}, 0);
        check("rst_rdata",   bus.rdata,   0);
        check("rst_ids",     {bus.bid, bus.rid}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic 4-beat write then read back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        write_burst(4'd5, 32'd16, 3, 3, resp, rbid);
        check("t1_bresp", resp, 2'b00);
        check("t1_bid",   rbid, 4'd5);
        read_burst(4'd9, 32'd16, 3, 1'b0);
        check("t1_latency", rd_wait, LAT - 1);
        for (int i = 0; i < 4; i++) begin
            check("t1_rdata", rd_data[i], 32'hA0 + 32'(i));
            check("t1_rresp", rd_resp[i], 2'b00);
            check("t1_rlast", rd_last[i], (i == 3));
            check("t1_rid",   rd_id[i],   4'd9);
        end

        // byte-strobe merge on mem[5]
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        write_burst(4'd1, 32'd5, 0, 0, resp, rbid);
        check("t2_bresp_full", resp, 2'b00);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        write_burst(4'd2, 32'd5, 0, 0, resp, rbid);
        check("t2_bid", rbid, 4'd2);

        // 8-beat read with rready toggling every cycle
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
        write_burst(4'd3, 32'd200, 7, 7, resp, rbid);
        check("t3_bresp", resp, 2'b00);
        read_burst(4'd7, 32'd200, 7, 1'b1);
        check("t3_stable", rd_unstable, 0);
        for (int i = 0; i < 8; i++) begin
            check("t3_rdata", rd_data[i], 32'hC0DE0000 + 32'(i));
            check("t3_rlast", rd_last[i], (i == 7));
        end

        // burst running off the end of memory
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hD000 + 32'(i); ws[i] = 4'hF; end
        write_burst(4'd4, 32'd1022, 3, 3, resp, rbid);
        check("t4_bresp", resp, 2'b10);
        read_burst(4'd4, 32'd1022, 3, 1'b0);
        check("t4_rresp0", rd_resp[0], 2'b00);
        check("t4_rresp1", rd_resp[1], 2'b00);
        check("t4_rresp2", rd_resp[2], 2'b10);
        check("t4_rresp3", rd_resp[3], 2'b10);
        check("t4_rdata0", rd_data[0], 32'hD000);
        check("t4_rdata1", rd_data[1], 32'hD001);
        check("t4_rdata2", rd_data[2], 32'h0);
        check("t4_rdata3", rd_data[3], 32'h0);
        check("t4_rlast3", rd_last[3], 1'b1);

        // wlast early, and wlast missing on the final beat
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hE000 + 32'(i); ws[i] = 4'hF; end
        write_burst(4'd6, 32'd300, 3, 2, resp, rbid);
        check("t5_bresp_early", resp, 2'b10);
        for (int i = 0; i < 2; i++) begin wd[i] = 32'h5100 + 32'(i); ws[i] = 4'hF; end
        write_burst(4'd6, 32'd310, 1, -1, resp, rbid);
        check("t5_bresp_nolast", resp, 2'b10);
        wd[0] = 32'h77; ws[0] = 4'hF;
        write_burst(4'd8, 32'd320, 0, 0, resp, rbid);
        check("t5_bresp_clears", resp, 2'b00);

        // reset during beat 2 of an 8-beat write
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hF000 + 32'(i); ws[i] = 4'hF; end
        bus.awid = 4'd2; bus.awaddr = 32'd400; bus.awlen = 8'd7; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = 1'b0; bus.wvalid = 1'b1;
            tick();
        end
        bus.wdata = wd[2]; bus.wvalid = 1'b1;
        check("t6_wready_pre", bus.wready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_wready_rst", bus.wready, 0);
        check("t6_bvalid_rst", bus.bvalid, 0);
        bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        check("t6_awready", bus.awready, 1);
        saw_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.bvalid) saw_b = 1'b1;
        end
        check("t6_no_b", saw_b, 0);
        bus.bready = 1'b0;

        // single-word readback table
        for (int k = 0; k < 19; k++) begin
            read_burst(4'd1, tbl[k].addr, 0, 1'b0);
            check($sformatf("tbl%0d_rdata", k), rd_data[0], tbl[k].exp_data);
            check($sformatf("tbl%0d_rresp", k), rd_resp[0], tbl[k].exp_resp);
            check($sformatf("tbl%0d_rlast", k), rd_last[0], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
